// File: rtl/register_file_pkg.sv
// register_file_pkg: default register file geometry and the register-address type shared with decode and writeback
package register_file_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 2;
  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: read, writeback and reserve signals between the pipeline and the register file
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = 2
);
  logic [READ_PORTS*ADDR_WIDTH-1:0] read_register;
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic [READ_PORTS-1:0] read_busy;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  logic write_enable;
  logic [ADDR_WIDTH-1:0] reserve_register;
  logic reserve_enable;
  logic [2**ADDR_WIDTH-1:0] busy_vector;
  modport master (
    output read_register, write_register, write_data, write_enable, reserve_register, reserve_enable,
    input read_data, read_busy, busy_vector
  );
  modport slave (
    input read_register, write_register, write_data, write_enable, reserve_register, reserve_enable,
    output read_data, read_busy, busy_vector
  );
endinterface

// File: rtl/register_file_read_port.sv
// register_file_read_port: one combinational read port with write bypass and optional zero register
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG = 0
) (
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    regs [2**ADDR_WIDTH],
  input  logic [2**ADDR_WIDTH-1:0] busy,
  input  logic                     byp_en,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH-1:0]    data,
  output logic                     busy_out
);
  logic hit, zero;
  always_comb begin
    zero = ZERO_REG != 0 && addr == '0;
    hit = byp_en && wr_addr == addr;
    data = zero ? '0 : hit ? wr_data : regs[addr];
    busy_out = !zero && !hit && busy[addr];
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port register file with writeback bypass and per-register busy scoreboard
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG = 0
) (
  input logic clock,
  input logic reset,
  register_file_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic [READ_PORTS-1:0] read_busy;
  logic byp_en;
  // reserve is applied after the write so a new producer wins over the retiring one
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (bus.write_enable) begin
      regs_d[bus.write_register] = bus.write_data;
      busy_d[bus.write_register] = 1'b0;
    end
    if (bus.reserve_enable) busy_d[bus.reserve_register] = 1'b1;
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  assign byp_en = bus.write_enable && !reset;
  genvar g;
  for (g = 0; g < READ_PORTS; g++) begin : g_rd
    register_file_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .addr(bus.read_register[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .regs(regs_q),
      .busy(busy_q),
      .byp_en(byp_en),
      .wr_addr(bus.write_register),
      .wr_data(bus.write_data),
      .data(read_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .busy_out(read_busy[g])
    );
  end
  assign bus.read_data = read_data;
  assign bus.read_busy = read_busy;
  assign bus.busy_vector = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: scoreboard bench for register_file_mp with and without the zero register
module tb_register_file_mp;
  import register_file_pkg::*;
  logic clock = 1'b0;
  logic reset;
  int compared = 0;
  int mismatched = 0;
  string tag_q[$];
  logic [63:0] exp_q[$];

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .READ_PORTS(2)) bus0();
  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .READ_PORTS(2)) bus1();

  register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .READ_PORTS(2), .ZERO_REG(0)) u_dut (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .READ_PORTS(2), .ZERO_REG(1)) u_dutz (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [63:0] got);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_empty: got %0h expected nothing", got);
    end else begin
      check(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus0.write_enable = 1'b0;
    bus0.reserve_enable = 1'b0;
    bus1.write_enable = 1'b0;
    bus1.reserve_enable = 1'b0;
  endtask

  task automatic drive_rd(input bit z, input reg_addr_t a0, input reg_addr_t a1,
                          input logic [31:0] d0, input logic [31:0] d1, input logic b0, input logic b1);
    if (z) bus1.read_register = {a1, a0};
    else bus0.read_register = {a1, a0};
    push($sformatf("%s_data0@r%0d", z ? "z" : "n", a0), {32'h0, d0});
    push($sformatf("%s_data1@r%0d", z ? "z" : "n", a1), {32'h0, d1});
    push($sformatf("%s_busy0@r%0d", z ? "z" : "n", a0), {63'h0, b0});
    push($sformatf("%s_busy1@r%0d", z ? "z" : "n", a1), {63'h0, b1});
  endtask

  task automatic sample(input bit z);
    #1;
    observe({32'h0, z ? bus1.read_data[31:0] : bus0.read_data[31:0]});
    observe({32'h0, z ? bus1.read_data[63:32] : bus0.read_data[63:32]});
    observe({63'h0, z ? bus1.read_busy[0] : bus0.read_busy[0]});
    observe({63'h0, z ? bus1.read_busy[1] : bus0.read_busy[1]});
  endtask

  task automatic check_bv(input bit z, input logic [3:0] exp);
    check(z ? "z_busy_vector" : "n_busy_vector", {60'h0, z ? bus1.busy_vector : bus0.busy_vector}, {60'h0, exp});
  endtask

  initial begin
    reg_addr_t a;
    reset = 1'b1;
    idle();
    bus0.read_register = '0;
    bus1.read_register = '0;
    bus0.write_register = '0;
    bus0.write_data = '0;
    bus0.reserve_register = '0;
    bus1.write_register = '0;
    bus1.write_data = '0;
    bus1.reserve_register = '0;
    tick();
    tick();
    reset = 1'b0;
    // reset state
    for (int i = 0; i < 4; i++) begin
      a = reg_addr_t'(i);
      drive_rd(0, a, a, 0, 0, 0, 0);
      sample(0);
      tick();
    end
    check_bv(0, 4'b0000);
    check_bv(1, 4'b0000);
    // consecutive writes 21, 42, 84, 168
    for (int i = 0; i < 4; i++) begin
      bus0.write_enable = 1'b1;
      bus0.write_register = reg_addr_t'(i);
      bus0.write_data = 32'd21 << i;
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      a = reg_addr_t'(i);
      drive_rd(0, a, a, 32'd21 << i, 32'd21 << i, 0, 0);
      sample(0);
      tick();
    end
    drive_rd(0, 2'd0, 2'd3, 21, 168, 0, 0);
    sample(0);
    // same-cycle bypass on port 1
    bus0.write_enable = 1'b1;
    bus0.write_register = 2'd2;
    bus0.write_data = 32'd99;
    drive_rd(0, 2'd1, 2'd2, 42, 99, 0, 0);
    sample(0);
    tick();
    idle();
    drive_rd(0, 2'd2, 2'd2, 99, 99, 0, 0);
    sample(0);
    // reserve visible only from the next cycle
    bus0.reserve_enable = 1'b1;
    bus0.reserve_register = 2'd3;
    drive_rd(0, 2'd3, 2'd0, 168, 21, 0, 0);
    sample(0);
    tick();
    idle();
    drive_rd(0, 2'd3, 2'd3, 168, 168, 1, 1);
    sample(0);
    check_bv(0, 4'b1000);
    bus0.write_enable = 1'b1;
    bus0.write_register = 2'd3;
    bus0.write_data = 32'd7;
    drive_rd(0, 2'd3, 2'd2, 7, 99, 0, 0);
    sample(0);
    check_bv(0, 4'b1000);
    tick();
    idle();
    check_bv(0, 4'b0000);
    drive_rd(0, 2'd3, 2'd3, 7, 7, 0, 0);
    sample(0);
    // write and reserve same register: new producer wins
    bus0.write_enable = 1'b1;
    bus0.write_register = 2'd1;
    bus0.write_data = 32'd5;
    bus0.reserve_enable = 1'b1;
    bus0.reserve_register = 2'd1;
    tick();
    idle();
    drive_rd(0, 2'd1, 2'd0, 5, 21, 1, 0);
    sample(0);
    check_bv(0, 4'b0010);
    // zero register instance
    bus1.write_enable = 1'b1;
    bus1.write_register = 2'd0;
    bus1.write_data = 32'd55;
    bus1.reserve_enable = 1'b1;
    bus1.reserve_register = 2'd0;
    drive_rd(1, 2'd0, 2'd0, 0, 0, 0, 0);
    sample(1);
    tick();
    idle();
    drive_rd(1, 2'd0, 2'd0, 0, 0, 0, 0);
    sample(1);
    check_bv(1, 4'b0000);
    bus1.write_enable = 1'b1;
    bus1.write_register = 2'd2;
    bus1.write_data = 32'd55;
    tick();
    idle();
    drive_rd(1, 2'd2, 2'd0, 55, 0, 0, 0);
    sample(1);
    // reset mid-stream with a write pending: no bypass, then everything cleared
    bus0.write_enable = 1'b1;
    bus0.write_register = 2'd2;
    bus0.write_data = 32'd123;
    reset = 1'b1;
    drive_rd(0, 2'd2, 2'd1, 99, 5, 0, 1);
    sample(0);
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      a = reg_addr_t'(i);
      drive_rd(0, a, a, 0, 0, 0, 0);
      sample(0);
      tick();
    end
    check_bv(0, 4'b0000);
    drive_rd(1, 2'd2, 2'd2, 0, 0, 0, 0);
    sample(1);
    check("scoreboard_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-read-port register file. Successor to the 4x32 single-read-port register file.
- Adds clocked writes, synchronous clear, same-cycle write-to-read bypass, an optional hardwired zero register and a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (read and reserve) and writeback (write) in the core datapath.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 2, register address bits; depth = 2**ADDR_WIDTH.
- READ_PORTS, 2, number of independent combinational read ports (>=1).
- ZERO_REG, 0, if 1, register 0 always reads 0 and is never busy; writes and reserves to it are ignored.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- read_register  in  READ_PORTS*ADDR_WIDTH  flattened read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  out  READ_PORTS*DATA_WIDTH  flattened read data, same packing.
- read_busy  out  READ_PORTS  1 = addressed register has a pending producer.
- write_register  in  ADDR_WIDTH  writeback destination.
- write_data  in  DATA_WIDTH  writeback value.
- write_enable  in  1  commit write_data at the next edge.
- reserve_register  in  ADDR_WIDTH  destination of a newly issued instruction.
- reserve_enable  in  1  set the busy bit of reserve_register at the next edge.
- busy_vector  out  2**ADDR_WIDTH  registered busy bit per register.

Behaviour:
- Storage: 2**ADDR_WIDTH x DATA_WIDTH registers plus a 2**ADDR_WIDTH busy vector, all flops.
- Reset, sampled on an edge with reset=1: all registers <= 0, busy <= 0. Writes and reserves in that cycle are dropped.
- Outputs after reset: read_data all 0, read_busy all 0, busy_vector 0.
- Write: on an edge with write_enable=1 and reset=0, reg[write_register] <= write_data and busy[write_register] <= 0.
- Reserve: on an edge with reserve_enable=1 and reset=0, busy[reserve_register] <= 1.
- Write and reserve to the same register in the same cycle: data is written and the busy bit ends at 1 (new producer wins).
- Write and reserve to different registers: both take effect independently.
- Reads are combinational, zero latency. For each port p with address a:
  - If write_enable=1, reset=0 and write_register==a: read_data = write_data (bypass) and read_busy = 0.
  - Otherwise: read_data = reg[a] and read_busy = busy[a].
  - A reserve never affects read outputs in its own cycle; it is visible from the next cycle.
- Bypass is suppressed while reset=1: reads return stored contents.
- ZERO_REG=1 and a==0: read_data = 0, read_busy = 0, with no bypass. busy_vector[0] stays 0.
- Multiple read ports may address the same register; each gets identical results.
- No write-port conflicts exist because there is a single write port.
- Addresses are full-range; no out-of-range case exists.
- busy_vector reflects flop state only, with no bypass.

Decomposition:
- Package register_file_pkg holds the default DATA_WIDTH and ADDR_WIDTH constants and a register-address typedef shared with decode and writeback.
- Sub-module register_file_read_port: address mux, bypass compare and zero-register override. Instantiated READ_PORTS times in a generate loop.
- Storage, busy scoreboard and write/reserve logic stay in the top module.

Test Plan:
- Reset then read all registers -> read_data=0, read_busy=0 and busy_vector=0 on every port.
- Write 21, 42, 84, 168 to registers 0-3 on consecutive edges (ZERO_REG=0), then read 0-3 on both ports -> 21/42/84/168 on both ports.
- Hold write_enable=1, write_register=2, write_data=99 with read_register port1=2 in the same cycle -> read_data port1=99 before the edge; stored value is 99 after the edge.
- Reserve register 3, then read it next cycle -> read_busy=1 and busy_vector=4'b1000. Write 7 to register 3 -> bypass 7 with read_busy=0 in that cycle; busy cleared after the edge.
- Same cycle: write register 1=5 and reserve register 1 -> after the edge, register 1 reads 5 with read_busy=1.
- ZERO_REG=1: write 55 and reserve register 0 -> read_data=0, read_busy=0, busy_vector[0]=0.
- Assert reset mid-stream with write_enable=1 -> no bypass that cycle; all state 0 after the edge.
